// File: rtl/mrd_mem_pkg.sv
// Shared constants and FSM state type for the mixed-radix memory write-back path.
package mrd_mem_pkg;
  localparam int NBANK = 5;
  localparam logic [2:0] BANK_LIMIT = 3'd5;
  localparam int W_DATA_DEF = 30;
  localparam int W_ADDR_DEF = 8;
  localparam int W_CNT_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/mrd_wr_xbar.sv
// 5x5 lane-to-bank crossbar; lowest lane wins a contested bank, out-of-range lanes are dropped.
module mrd_wr_xbar
  import mrd_mem_pkg::*;
#(
  parameter int wDataInOut = W_DATA_DEF,
  parameter int wAddr      = W_ADDR_DEF
) (
  input  logic [NBANK-1:0][2:0]            bank_index_i,
  input  logic [NBANK-1:0][wAddr-1:0]      bank_addr_i,
  input  logic [NBANK-1:0][wDataInOut-1:0] real_i,
  input  logic [NBANK-1:0][wDataInOut-1:0] imag_i,
  output logic [NBANK-1:0]                 wren_o,
  output logic [NBANK-1:0][wAddr-1:0]      waddr_o,
  output logic [NBANK-1:0][wDataInOut-1:0] wreal_o,
  output logic [NBANK-1:0][wDataInOut-1:0] wimag_o,
  output logic                             collision_o,
  output logic                             index_err_o
);

  always_comb begin
    wren_o      = '0;
    waddr_o     = '0;
    wreal_o     = '0;
    wimag_o     = '0;
    collision_o = 1'b0;
    index_err_o = 1'b0;
    // Ascending scan: a bank already claimed means a higher lane lost the race.
    for (int k = 0; k < NBANK; k++) begin
      if (bank_index_i[k] >= BANK_LIMIT) begin
        index_err_o = 1'b1;
      end else if (wren_o[bank_index_i[k]]) begin
        collision_o = 1'b1;
      end else begin
        wren_o[bank_index_i[k]]  = 1'b1;
        waddr_o[bank_index_i[k]] = bank_addr_i[k];
        wreal_o[bank_index_i[k]] = real_i[k];
        wimag_o[bank_index_i[k]] = imag_i[k];
      end
    end
  end

endmodule

// File: rtl/mrd_mem_wrback.sv
// Stage write-back controller: counts beats of a stage and registers crossbar writes to 5 banks.
module mrd_mem_wrback
  import mrd_mem_pkg::*;
#(
  parameter int wDataInOut = W_DATA_DEF,
  parameter int wAddr      = W_ADDR_DEF,
  parameter int wCnt       = W_CNT_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [wCnt-1:0]                  wr_total,
  input  logic                             in_valid,
  input  logic [NBANK-1:0][2:0]            in_bank_index,
  input  logic [NBANK-1:0][wAddr-1:0]      in_bank_addr,
  input  logic [NBANK-1:0][wDataInOut-1:0] in_real,
  input  logic [NBANK-1:0][wDataInOut-1:0] in_imag,
  output logic [NBANK-1:0]                 bank_wren,
  output logic [NBANK-1:0][wAddr-1:0]      bank_waddr,
  output logic [NBANK-1:0][wDataInOut-1:0] bank_wreal,
  output logic [NBANK-1:0][wDataInOut-1:0] bank_wimag,
  output logic                             busy,
  output logic                             done,
  output logic                             err_collision,
  output logic                             err_index,
  output logic                             err_overrun
);

  state_e                          state_q, state_d;
  logic [wCnt-1:0]                 cnt_q, cnt_d;
  logic                            accept, overrun;
  logic [NBANK-1:0]                x_wren;
  logic [NBANK-1:0][wAddr-1:0]      x_waddr;
  logic [NBANK-1:0][wDataInOut-1:0] x_wreal, x_wimag;
  logic                            x_coll, x_idx;

  logic [NBANK-1:0]                 wren_q;
  logic [NBANK-1:0][wAddr-1:0]      waddr_q;
  logic [NBANK-1:0][wDataInOut-1:0] wreal_q, wimag_q;
  logic                             coll_q, idx_q, ovr_q;

  mrd_wr_xbar #(
    .wDataInOut(wDataInOut),
    .wAddr     (wAddr)
  ) u_xbar (
    .bank_index_i(in_bank_index),
    .bank_addr_i (in_bank_addr),
    .real_i      (in_real),
    .imag_i      (in_imag),
    .wren_o      (x_wren),
    .waddr_o     (x_waddr),
    .wreal_o     (x_wreal),
    .wimag_o     (x_wimag),
    .collision_o (x_coll),
    .index_err_o (x_idx)
  );

  // Beats only land while WRITE is active; anything else is an overrun, including start+valid in IDLE.
  assign accept  = in_valid && (state_q == ST_WRITE);
  assign overrun = in_valid && (state_q != ST_WRITE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = wr_total;
          state_d = (wr_total == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (in_valid) begin
          cnt_d = cnt_q - wCnt'(1);
          if (cnt_q == wCnt'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wren_q  <= '0;
      waddr_q <= '0;
      wreal_q <= '0;
      wimag_q <= '0;
      coll_q  <= 1'b0;
      idx_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wren_q  <= accept ? x_wren : '0;
      if (accept) begin
        waddr_q <= x_waddr;
        wreal_q <= x_wreal;
        wimag_q <= x_wimag;
      end
      coll_q <= coll_q | (accept & x_coll);
      idx_q  <= idx_q  | (accept & x_idx);
      ovr_q  <= ovr_q  | overrun;
    end
  end

  // DONE is entered on the same edge that registers the last beat, so done lines up with its wren.
  assign done          = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign bank_wren     = wren_q;
  assign bank_waddr    = waddr_q;
  assign bank_wreal    = wreal_q;
  assign bank_wimag    = wimag_q;
  assign err_collision = coll_q;
  assign err_index     = idx_q;
  assign err_overrun   = ovr_q;

endmodule

// File: tb/tb_mrd_mem_wrback.sv
// Directed bench for mrd_mem_wrback: stage sequencing, crossbar routing, error flags, reset abort.
module tb_mrd_mem_wrback;
  localparam int W  = 30;
  localparam int WA = 8;
  localparam int WC = 12;
  localparam int NB = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [WC-1:0]            wr_total;
  logic                     in_valid;
  logic [NB-1:0][2:0]       in_bank_index;
  logic [NB-1:0][WA-1:0]    in_bank_addr;
  logic [NB-1:0][W-1:0]     in_real, in_imag;
  logic [NB-1:0]            bank_wren;
  logic [NB-1:0][WA-1:0]    bank_waddr;
  logic [NB-1:0][W-1:0]     bank_wreal, bank_wimag;
  logic                     busy, done, err_collision, err_index, err_overrun;

  int n_cmp = 0;
  int n_err = 0;

  mrd_mem_wrback #(.wDataInOut(W), .wAddr(WA), .wCnt(WC)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_total(wr_total), .in_valid(in_valid),
    .in_bank_index(in_bank_index), .in_bank_addr(in_bank_addr),
    .in_real(in_real), .in_imag(in_imag),
    .bank_wren(bank_wren), .bank_waddr(bank_waddr),
    .bank_wreal(bank_wreal), .bank_wimag(bank_wimag),
    .busy(busy), .done(done),
    .err_collision(err_collision), .err_index(err_index), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane k: address 10+k, real base+k, imag -(base+k).
  task automatic set_beat(input logic [NB-1:0][2:0] idx, input int base);
    in_bank_index = idx;
    for (int k = 0; k < NB; k++) begin
      in_bank_addr[k] = WA'(10 + k);
      in_real[k]      = W'(base + k);
      in_imag[k]      = W'(-(base + k));
    end
  endtask

  task automatic chk_errs(input string tag, input logic c, input logic i, input logic o);
    chk({tag, "_err"}, {err_collision, err_index, err_overrun}, {c, i, o});
  endtask

  logic [W-1:0] exp_d;

  initial begin
    rst = 1'b1; start = 1'b0; wr_total = '0; in_valid = 1'b0;
    set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1);
    step(); step();
    chk("rst_wren", bank_wren, 5'b0);
    chk("rst_waddr", bank_waddr, '0);
    chk("rst_wreal", bank_wreal, '0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk_errs("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Three-beat identity stage
    start = 1'b1; wr_total = 12'd3; step();
    start = 1'b0;
    chk("s1_arm", {busy, done, bank_wren}, {2'b10, 5'b0});
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1 + 10 * b);
      step();
      chk("s1_wren", bank_wren, 5'b11111);
      chk("s1_done", {busy, done}, (b == 2) ? 2'b11 : 2'b10);
      for (int k = 0; k < NB; k++) begin
        chk("s1_waddr", bank_waddr[k], WA'(10 + k));
        exp_d = W'(1 + 10 * b + k);
        chk("s1_wreal", bank_wreal[k], exp_d);
        exp_d = W'(-(1 + 10 * b + k));
        chk("s1_wimag", bank_wimag[k], exp_d);
      end
    end
    in_valid = 1'b0; step();
    chk("s1_end", {busy, done, bank_wren}, {2'b00, 5'b0});

    // Reversed routing
    start = 1'b1; wr_total = 12'd1; step();
    start = 1'b0; in_valid = 1'b1;
    set_beat({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 100);
    step();
    in_valid = 1'b0;
    chk("rev_wren", bank_wren, 5'b11111);
    chk("rev_bank4", bank_wreal[4], 30'd100);
    chk("rev_bank0", bank_wreal[0], 30'd104);
    chk("rev_addr0", bank_waddr[0], 8'd14);
    chk("rev_done", done, 1'b1);
    chk_errs("rev", 1'b0, 1'b0, 1'b0);
    step();

    // Collision: lanes 0 and 1 both target bank 2
    start = 1'b1; wr_total = 12'd2; step();
    start = 1'b0; in_valid = 1'b1;
    set_beat({3'd3, 3'd1, 3'd0, 3'd2, 3'd2}, 200);
    step();
    chk("col_wren", bank_wren, 5'b01111);
    chk("col_bank2", bank_wreal[2], 30'd200);
    chk("col_bank0", bank_wreal[0], 30'd202);
    chk("col_bank3", bank_wreal[3], 30'd204);
    chk_errs("col", 1'b1, 1'b0, 1'b0);
    set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 300);
    step();
    in_valid = 1'b0;
    chk("col2_wren", bank_wren, 5'b11111);
    chk_errs("col_sticky", 1'b1, 1'b0, 1'b0);
    step();

    // Out-of-range bank index on lane 3
    start = 1'b1; wr_total = 12'd1; step();
    start = 1'b0; in_valid = 1'b1;
    set_beat({3'd4, 3'd6, 3'd2, 3'd1, 3'd0}, 400);
    step();
    in_valid = 1'b0;
    chk("idx_wren", bank_wren, 5'b10111);
    chk("idx_bank4", bank_wreal[4], 30'd404);
    chk_errs("idx", 1'b1, 1'b1, 1'b0);
    step();

    // Overrun in IDLE, then a zero-length stage
    in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("ovr_wren", bank_wren, 5'b0);
    chk_errs("ovr", 1'b1, 1'b1, 1'b1);
    start = 1'b1; wr_total = 12'd0; step();
    start = 1'b0;
    chk("zero_done", {busy, done, bank_wren}, {2'b11, 5'b0});
    step();
    chk("zero_idle", {busy, done, bank_wren}, {2'b00, 5'b0});

    // Reset mid-stage after two of five beats
    start = 1'b1; wr_total = 12'd5; step();
    start = 1'b0; in_valid = 1'b1;
    set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 500); step();
    set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 510); step();
    chk("ab_wren", bank_wren, 5'b11111);
    set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 520);
    rst = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0;
    chk("ab_wren0", bank_wren, 5'b0);
    chk("ab_wreal0", bank_wreal, '0);
    chk("ab_waddr0", bank_waddr, '0);
    chk("ab_busy_done", {busy, done}, 2'b00);
    chk_errs("ab", 1'b0, 1'b0, 1'b0);
    step();
    chk("ab_quiet", {busy, done, bank_wren}, {2'b00, 5'b0});
    start = 1'b1; wr_total = 12'd1; step();
    start = 1'b0; in_valid = 1'b1;
    set_beat({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 600); step();
    in_valid = 1'b0;
    chk("post_wren", bank_wren, 5'b11111);
    chk("post_done", {busy, done}, 2'b11);
    chk("post_bank1", bank_wreal[1], 30'd601);
    step();
    chk("post_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mrd_mem_wrback.md
MRD_MEM_WRBACK -- requirements
Module: mrd_mem_wrback

Interface
REQ-001 SHALL have parameter wDataInOut, default 30, meaning sample component width (real and imag).
REQ-002 SHALL have parameter wAddr, default 8, meaning per-bank address width.
REQ-003 SHALL have parameter wCnt, default 12, meaning beat-counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that arms a stage.
REQ-007 SHALL have port wr_total  input  wCnt  beats expected in the stage, sampled with start.
REQ-008 SHALL have port in_valid  input  1  one radix-result beat of 5 samples.
REQ-009 SHALL have port in_bank_index  input  5x3  target bank of lanes 0..4.
REQ-010 SHALL have port in_bank_addr  input  5xwAddr  target address of lanes 0..4.
REQ-011 SHALL have ports in_real and in_imag  input  5xwDataInOut signed  lane samples.
REQ-012 SHALL have port bank_wren  output  5  write enable of banks 0..4.
REQ-013 SHALL have port bank_waddr  output  5xwAddr  write address of each bank.
REQ-014 SHALL have ports bank_wreal and bank_wimag  output  5xwDataInOut  write data of each bank.
REQ-015 SHALL have port busy  output  1  high while a stage is armed.
REQ-016 SHALL have port done  output  1  one-cycle stage-complete pulse.
REQ-017 SHALL have ports err_collision, err_index, err_overrun  output  1 each  sticky error flags.

Function
REQ-018 SHALL route lane k to bank in_bank_index[k] at in_bank_addr[k]; the 5x5 crossbar SHALL be selected per beat.
REQ-019 SHALL register all bank_* outputs: latency from accepted in_valid to bank_wren exactly 1 cycle.
REQ-020 SHALL pass sample data bit-exact; no rounding, saturation or sign change.
REQ-021 SHALL, when two or more lanes target one bank in a beat, write only the lowest-numbered lane and set err_collision.
REQ-022 SHALL, when in_bank_index[k] > 4, drop lane k and set err_index.
REQ-023 SHALL implement FSM IDLE, WRITE, DONE.
REQ-024 IDLE: start loads beat counter with wr_total and moves to WRITE; if wr_total = 0 moves directly to DONE.
REQ-025 WRITE: each in_valid decrements counter and is written; accepting the beat that makes counter zero moves to DONE.
REQ-026 DONE: asserts done for exactly one cycle, coincident with bank_wren of the last beat, then returns to IDLE.
REQ-027 busy SHALL be high in WRITE and DONE, low in IDLE.
REQ-028 in_valid in IDLE or DONE SHALL be discarded (no bank_wren) and set err_overrun.
REQ-029 start outside IDLE SHALL be ignored; start and in_valid in the same IDLE cycle: in_valid discarded, err_overrun set.
REQ-030 Error flags SHALL clear only on rst.

Reset
REQ-031 rst SHALL force IDLE, counter 0, bank_wren 0, bank_waddr 0, bank_wreal/bank_wimag 0, busy 0, done 0, all error flags 0.
REQ-032 rst mid-stage SHALL abort the stage the next edge; the in-flight beat SHALL NOT be written and done SHALL NOT pulse.

Structure
REQ-033 Package mrd_mem_pkg SHALL hold NBANK = 5, default wDataInOut, wAddr, wCnt and the FSM state enum.
REQ-034 Crossbar and collision/index detection SHALL be a combinational sub-module mrd_wr_xbar; FSM, counter and output registers stay in mrd_mem_wrback.

Verification
REQ-035 start, wr_total=3, three beats with bank_index {0,1,2,3,4}, addr k+10 -> bank k written addr k+10 each beat, done high on third write cycle, busy low next cycle.
REQ-036 Beat with bank_index {4,3,2,1,0}, lane data 100..104 -> bank 4 gets 100, bank 0 gets 104, one cycle later; no error flags.
REQ-037 Beat with bank_index {2,2,0,1,3} -> bank 2 gets lane 0 data, bank 4 wren 0, err_collision = 1 and stays 1.
REQ-038 Lane 3 bank_index = 6 -> lane 3 dropped, err_index = 1, other four lanes written.
REQ-039 in_valid with no start -> all bank_wren 0, err_overrun = 1; start with wr_total=0 -> done pulse next cycle, no writes.
REQ-040 rst asserted after 2 of 5 beats -> outputs zero next cycle, no done pulse, busy 0, later stage runs normally.
